// File: rtl/rob_tracker.sv
// Reorder buffer tracker: in-order allocate, CDB capture, in-order commit, operand lookup.
// Optional ROB_FULL_LOOKAHEAD_EN raises rob_full one entry early for stall slack.
module rob_tracker #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_dest,
  output logic [TAG_W-1:0]  issue_tag,
  output logic              rob_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag
);

  localparam int unsigned CNT_W = TAG_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NEAR_FULL_CNT = CNT_W'(DEPTH - 1);

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  ready;
  logic [REG_W-1:0]  dest  [DEPTH];
  logic [DATA_W-1:0] value [DEPTH];

  logic full_hard;
  logic issue_fire;
  logic cdb_fire;
  logic commit_fire;

  // Allocation is refused only when every entry is truly occupied; the
  // lookahead variant merely warns the stall logic one entry earlier.
  always_comb begin
    full_hard = (count == FULL_CNT);
`ifdef ROB_FULL_LOOKAHEAD_EN
    rob_full  = (count >= NEAR_FULL_CNT);
`else
    rob_full  = full_hard;
`endif
    issue_fire  = issue_valid && !full_hard;
    commit_fire = busy[head] && ready[head];
    // A broadcast loses to a same-edge allocation or retirement of its entry.
    cdb_fire    = cdb_valid && busy[cdb_tag]
                  && !(issue_fire && (cdb_tag == tail))
                  && !(commit_fire && (cdb_tag == head));
    issue_tag   = tail;
  end

  // Operand lookup reads only captured results; no same-cycle CDB bypass.
  always_comb begin
    q1_ready = busy[q1_tag] && ready[q1_tag];
    q2_ready = busy[q2_tag] && ready[q2_tag];
    q1_data  = q1_ready ? value[q1_tag] : '0;
    q2_data  = q2_ready ? value[q2_tag] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      commit_tag   <= '0;
    end else begin
      if (commit_fire) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + TAG_W'(1);
      end
      if (cdb_fire) begin
        ready[cdb_tag] <= 1'b1;
      end
      if (issue_fire) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tail        <= tail + TAG_W'(1);
      end
      case ({issue_fire, commit_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      commit_valid <= commit_fire;
      if (commit_fire) begin
        commit_reg  <= dest[head];
        commit_data <= value[head];
        commit_tag  <= head;
      end
    end
  end

  // Payload storage needs no reset; busy/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (issue_fire) begin
      dest[tail] <= issue_dest;
    end
    if (cdb_fire) begin
      value[cdb_tag] <= cdb_data;
    end
  end

endmodule
